serial_byte_feeder: RTL

- Upstream stage for the 8-bit serial-in shift register.
- Accepts parallel bytes over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Serializes each byte onto DATA_OUT, one bit per cycle, and drives SHIFT_ENABLE so that the downstream register captures exactly WIDTH bits per byte.
- Bytes are sent back-to-back, or separated by a programmable idle gap.

---
 rtl/serial_byte_feeder_if.sv | 12 +
 rtl/serial_byte_feeder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/serial_byte_feeder_if.sv
// Parallel-word handshake bundle feeding the serial byte feeder.
// The producer drives DIN/DIN_VALID; the feeder answers with DIN_READY.
interface serial_byte_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DIN;
  logic             DIN_VALID;
  logic             DIN_READY;

  modport master (output DIN, output DIN_VALID, input DIN_READY);
  modport slave  (input DIN, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/serial_byte_feeder.sv
// Buffers parallel words in a 2-entry FIFO and serializes them for the
// downstream serial-in shift register, with optional idle gap between words.
module serial_byte_feeder #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  serial_byte_feeder_if.slave  din_bus,
  input  logic                 HOLD,
  output logic                 DATA_OUT,
  output logic                 SHIFT_ENABLE,
  output logic                 BYTE_DONE,
  output logic                 BUSY
);
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] fifo_mem [2];
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count;
  logic [WIDTH-1:0] shifter;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic             push, pop, do_shift, gap_start, last_bit;

  // Readiness looks only at occupancy, so a full FIFO refuses even on a pop edge.
  assign din_bus.DIN_READY = ~RESET & (count < 2'd2);
  assign push              = din_bus.DIN_VALID & din_bus.DIN_READY;
  assign last_bit          = (bit_cnt == LAST_BIT);

  assign DATA_OUT = (state == SHIFT) & (MSB_FIRST ? shifter[WIDTH-1] : shifter[0]);
  assign BUSY     = (state != IDLE) | (count != 2'd0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    do_shift     = 1'b0;
    gap_start    = 1'b0;
    SHIFT_ENABLE = 1'b0;
    BYTE_DONE    = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != 2'd0) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        SHIFT_ENABLE = ~HOLD;
        if (!HOLD) begin
          do_shift = 1'b1;
          if (last_bit) begin
            BYTE_DONE = 1'b1;
            if (GAP_CYCLES == 0 && count != 2'd0) begin
              pop = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              gap_start = 1'b1;
              state_nxt = GAP;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          if (count != 2'd0) begin
            pop       = 1'b1;
            state_nxt = SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage is only meaningful under count, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= din_bus.DIN;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      shifter <= '0;
      bit_cnt <= '0;
      gap_cnt <= 4'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};

      if (pop) begin
        shifter <= fifo_mem[rd_ptr];
        bit_cnt <= '0;
      end else if (do_shift) begin
        shifter <= MSB_FIRST ? (shifter << 1) : (shifter >> 1);
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end

      if (gap_start)                            gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
    end
  end
endmodule
